// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MIPS MEM-stage data memory with sub-word access, fault detection and wait states
//
// Ports:
//   Clk, Rst         : clock and synchronous active-high reset
//   Address          : byte address of the access
//   writeData        : store data (byte uses [7:0], halfword uses [15:0])
//   MemRead/MemWrite : load / store request
//   Size             : 00 byte, 01 halfword, 10 word, 11 reserved
//   Unsigned         : zero-extend (1) or sign-extend (0) sub-word loads
//   ReadData         : registered, extended load result
//   Ack              : registered one-cycle pulse when an access completes
//   Fault            : registered one-cycle pulse when a request is rejected
//   Stall            : combinational; requester holds its inputs while high
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           writeData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [31:0]           ReadData,
  output logic                  Ack,
  output logic                  Fault,
  output logic                  Stall
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0] CNT_INIT = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e           state_q;
  logic [2:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             write_q;
  logic [31:0]      rdata_q;
  logic             ack_q;
  logic             fault_q;
  logic [31:0]      mem_q [DEPTH];

  logic             req;
  logic             bad;
  logic             in_idle;
  logic             new_ok;
  logic             wait_done;
  logic             acc_go;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_off;
  logic [31:0]      acc_wdata;
  logic [1:0]       acc_size;
  logic             acc_uns;
  logic             acc_write;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      rword;
  logic [7:0]       bsel;
  logic [15:0]      hsel;
  logic [31:0]      rdata_d;

  assign req = MemRead | MemWrite;

  always_comb begin
    bad = 1'b0;
    if (MemRead && MemWrite)                     bad = 1'b1;
    if (Size == 2'b11)                           bad = 1'b1;
    if (Size == 2'b01 && Address[0])             bad = 1'b1;
    if (Size == 2'b10 && Address[1:0] != 2'b00)  bad = 1'b1;
    if ({2'b00, Address[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH)) bad = 1'b1;
  end

  assign in_idle   = (state_q == S_IDLE);
  assign new_ok    = in_idle & req & ~bad;
  assign wait_done = (state_q == S_WAIT) & (cnt_q == 3'd0);

  // Zero wait states access straight from the live inputs; otherwise the
  // access is always taken from the copy latched on entry to WAIT.
  assign acc_go    = ~Rst & (HAS_WAIT ? wait_done : new_ok);
  assign acc_idx   = HAS_WAIT ? idx_q   : Address[IDX_W+1:2];
  assign acc_off   = HAS_WAIT ? off_q   : Address[1:0];
  assign acc_wdata = HAS_WAIT ? wdata_q : writeData;
  assign acc_size  = HAS_WAIT ? size_q  : Size;
  assign acc_uns   = HAS_WAIT ? uns_q   : Unsigned;
  assign acc_write = HAS_WAIT ? write_q : MemWrite;

  // Replicate sub-word store data across lanes; the byte enables pick the lane.
  always_comb begin
    be    = 4'b1111;
    wword = acc_wdata;
    case (acc_size)
      2'b00: begin
        be    = 4'b0001 << acc_off;
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = acc_off[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
    endcase
  end

  always_comb begin
    rword = mem_q[acc_idx];
    bsel  = rword[{acc_off, 3'b000} +: 8];
    hsel  = acc_off[1] ? rword[31:16] : rword[15:0];
    case (acc_size)
      2'b00:   rdata_d = acc_uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   rdata_d = acc_uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      default: rdata_d = rword;
    endcase
  end

  // Memory array has no reset; contents survive Rst.
  always_ff @(posedge Clk) begin
    if (acc_go && acc_write) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[acc_idx][8*k +: 8] <= wword[8*k +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      ack_q   <= acc_go;
      fault_q <= in_idle & req & bad;
      if (acc_go && !acc_write) rdata_q <= rdata_d;
      if (state_q == S_IDLE) begin
        if (new_ok && HAS_WAIT) begin
          idx_q   <= Address[IDX_W+1:2];
          off_q   <= Address[1:0];
          wdata_q <= writeData;
          size_q  <= Size;
          uns_q   <= Unsigned;
          write_q <= MemWrite;
          cnt_q   <= CNT_INIT;
          state_q <= S_WAIT;
        end
      end else begin
        if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
        else               state_q <= S_IDLE;
      end
    end
  end

  assign ReadData = rdata_q;
  assign Ack      = ack_q;
  assign Fault    = fault_q;
  assign Stall    = ~Rst & ((new_ok & HAS_WAIT) | ((state_q == S_WAIT) & (cnt_q != 3'd0)));

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the MIPS datapath, successor to the fixed word-only data memory. Adds byte/halfword/word loads and stores with sign or zero extension, alignment and range fault detection, and a configurable number of wait states with a `Stall` output that holds the pipeline's MEM stage. It sits in the MEM stage between the ALU result/store-data path and the write-back mux.

## Interface
- `ADDR_WIDTH`, 32: width of `Address`.
- `DEPTH`, 1024: number of 32-bit words; power of two, at least 4.
- `WAIT_STATES`, 0: extra cycles per access, 0..7.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Rst` input 1: synchronous, active-high reset, sampled on the rising edge of `Clk`.
- `Address` input ADDR_WIDTH: byte address.
- `writeData` input 32: store data; a byte store uses bits [7:0], a halfword store uses bits [15:0].
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request.
- `Size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `Unsigned` input 1: 1 zero-extends loads, 0 sign-extends them. Ignored for words and stores.
- `ReadData` output 32: registered, extended load result.
- `Ack` output 1: registered; one-cycle pulse when a read or write completes.
- `Fault` output 1: registered; one-cycle pulse when a request is rejected.
- `Stall` output 1: combinational; the requester must hold its inputs while this is high.

## Operation
- Request: `MemRead | MemWrite` sampled in IDLE.
- Fault conditions, checked in IDLE:
  - `MemRead & MemWrite`
  - `Size == 11`
  - halfword with `Address[0]` = 1
  - word with `Address[1:0]` ≠ 00
  - word index `Address[ADDR_WIDTH-1:2]` ≥ `DEPTH`
- On a faulting request:
  - no memory access; `Fault` = 1 in the next cycle; `Ack` = 0; `ReadData` holds.
  - `Stall` stays low and the FSM stays in IDLE.
- Byte lanes are little-endian: offset k = `Address[1:0]` maps to bits [8k+7:8k]. Halfword offset 0 maps to [15:0], offset 2 to [31:16].
- Stores write only the addressed lanes; all other lanes keep their contents.
- Loads:
  - Extract the addressed byte or halfword, right-justify it, then extend per `Unsigned`.
  - Word loads are passed through unchanged.
- FSM states:
  - IDLE:
    - A valid request with `WAIT_STATES` = 0 performs the access at this edge and stays in IDLE.
    - A valid request with `WAIT_STATES` = N > 0 latches `Address`, `writeData`, `Size`, `Unsigned` and the operation, loads cnt = N−1, and goes to WAIT.
  - WAIT:
    - If cnt ≠ 0, decrement cnt.
    - If cnt = 0, perform the access from the latched request and return to IDLE.
    - Inputs are ignored while in WAIT.
- `Stall` = `~Rst & ((IDLE & valid request & WAIT_STATES>0) | (WAIT & cnt≠0))`.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset, on the edge where `Rst` = 1:
  - state = IDLE, cnt = 0, `ReadData` = 0, `Ack` = 0, `Fault` = 0.
  - `Stall` is forced to 0 while `Rst` is high.
- Reset in the middle of a transaction abandons it: no write is performed and no `Ack` is produced.
- A request is presented in cycle 0; the access happens at the end of cycle N (N = `WAIT_STATES`).
- `ReadData` and `Ack` are valid in cycle N+1. The load-to-use latency is therefore N+1 cycles.
- `Stall` is high in cycles 0..N−1 and low in cycle N, so the pipeline advances at the access edge.
- Back-to-back requests:
  - With N = 0, one access completes per cycle.
  - With N > 0, a new request is accepted in the cycle after the return to IDLE. The throughput is one access per N+1 cycles.
- A read of a word that was written in the previous cycle returns the new data.
- `Ack` and `Fault` are never high together.

## Test plan
- N = 0:
  - Stimulus: sw 0xDEADBEEF @0x10, then lw @0x10 in the next cycle.
  - Required: `ReadData` = 0xDEADBEEF and `Ack` = 1 exactly one cycle after the lw; `Stall` is never high.
- Sub-word stores and loads:
  - Stimulus: sw 0x11223344 @0x20; sb 0xAA @0x21; then run each load below.
  - lbu @0x21 → 0x000000AA.
  - lb @0x21 → 0xFFFFFFAA.
  - lh @0x22 → 0x00001122.
  - lw @0x20 → 0x1122AA44.
- Faults:
  - Stimulus: lh @0x23, lw @0x22, `Size` = 11, both `MemRead` and `MemWrite` high, lw @(`DEPTH`·4).
  - Required: each produces a `Fault` pulse 1 cycle later with `Ack` = 0 and `ReadData` unchanged. A follow-up word read confirms memory is unchanged.
- N = 3:
  - Stimulus: lw @0x10, with `Address` changed during the stall.
  - Required: `Stall` high for cycles 0–2 and low in cycle 3; `Ack` and the data come from the latched address in cycle 4.
- N = 3, reset mid-transaction:
  - Stimulus: sw 0x55 @0x30 (prior content 0x0), with `Rst` pulsed in cycle 1.
  - Required: no `Ack`; `Stall` = 0 after the reset; a later lw @0x30 returns 0x0.
- Reset values:
  - Stimulus: `Rst` held high for 2 cycles with a request present.
  - Required: `ReadData` = 0, `Ack` = 0, `Fault` = 0, `Stall` = 0.
